sc1602_lcd_responder: RTL

// Responder end of the SC1602 (HD44780-compatible) 4-bit write bus: accepts en/rs/rw/data strobes

---
 rtl/sc1602_lcd_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sc1602_lcd_responder.sv
// rtl/sc1602_lcd_responder.sv - SC1602/HD44780 4-bit write-bus responder with 80-byte DDRAM mirror
// Optional busy-counter timing model enabled by defining SC1602_BUSY_MODEL_EN.
module sc1602_lcd_responder #(
    parameter int unsigned CMD_BUSY  = 2,
    parameter int unsigned CLR_BUSY  = 400,
    parameter int unsigned HOME_BUSY = 400
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sc1602_en,
    input  logic       sc1602_rs,
    input  logic       sc1602_rw,
    input  logic [3:0] sc1602_data,
    input  logic [6:0] mon_addr,
    output logic [7:0] mon_data,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       four_bit,
    output logic [6:0] ac,
    output logic       busy,
    output logic       timing_err
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_en_q, r_rs_q, r_rw_q;
    logic [3:0] r_data_q;
    logic [3:0] r_hi_nib;
    logic       r_phase_low;
    logic       r_exec, r_exec_rs;
    logic [7:0] r_exec_byte;
    logic       r_id;
    logic       r_cgram_sel;
    logic [6:0] r_clr_idx;
    logic [7:0] r_ddram [0:79];

    logic       w_strobe, w_fill, w_busy, w_is_clear;
    logic       w_ac_valid, w_mon_valid;
    logic [6:0] w_ac_idx, w_mon_idx;

    function automatic logic addr_valid(input logic [6:0] a, input logic tl);
        if (tl) return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
        return a <= 7'h4F;
    endfunction

    function automatic logic [6:0] addr_index(input logic [6:0] a, input logic tl);
        if (tl && a[6]) return a - 7'd24;
        return a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic tl);
        if (tl) begin
            if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end
        if (inc) return (a >= 7'h4F) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h4F : a - 7'd1;
    endfunction

    // Out-of-line DDRAM-set addresses fold back onto the start of a valid line.
    function automatic logic [6:0] set_addr(input logic [6:0] a, input logic tl);
        if (tl) begin
            if (a >= 7'h28 && a <= 7'h3F) return 7'h40;
            if (a >= 7'h68) return 7'h00;
            return a;
        end
        return (a >= 7'h50) ? 7'h00 : a;
    endfunction

    assign w_strobe    = r_en_q && !sc1602_en;
    assign w_is_clear  = r_exec && !r_exec_rs && (r_exec_byte == 8'h01);
    assign w_ac_valid  = addr_valid(ac, two_line);
    assign w_ac_idx    = addr_index(ac, two_line);
    assign w_mon_valid = addr_valid(mon_addr, two_line);
    assign w_mon_idx   = addr_index(mon_addr, two_line);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_is_clear) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_idx == 7'd79) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fill = (r_state == ST_CLEAR);
    end

`ifdef SC1602_BUSY_MODEL_EN
    logic [15:0] r_busy_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy_cnt <= '0;
        end else if (r_exec) begin
            if (w_is_clear)                                    r_busy_cnt <= 16'(CLR_BUSY);
            else if (!r_exec_rs && r_exec_byte[7:1] == 7'h01)  r_busy_cnt <= 16'(HOME_BUSY);
            else                                               r_busy_cnt <= 16'(CMD_BUSY);
        end else if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - 16'd1;
        end
    end

    assign w_busy = w_fill || (r_busy_cnt != '0);
`else
    assign w_busy = w_fill;
`endif

    assign busy = w_busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_en_q <= 1'b0; r_rs_q <= 1'b0; r_rw_q <= 1'b0; r_data_q <= 4'h0;
            r_hi_nib <= 4'h0; r_phase_low <= 1'b0;
            r_exec <= 1'b0; r_exec_rs <= 1'b0; r_exec_byte <= 8'h00;
            r_id <= 1'b1; r_cgram_sel <= 1'b0; r_clr_idx <= 7'd0;
            four_bit <= 1'b0; two_line <= 1'b0;
            disp_on <= 1'b0; cursor_on <= 1'b0; blink_on <= 1'b0;
            ac <= 7'h00; timing_err <= 1'b0; mon_data <= 8'h20;
        end else begin
            r_en_q   <= sc1602_en;
            r_rs_q   <= sc1602_rs;
            r_rw_q   <= sc1602_rw;
            r_data_q <= sc1602_data;
            r_exec   <= 1'b0;
            r_clr_idx <= w_fill ? r_clr_idx + 7'd1 : 7'd0;
            mon_data <= w_mon_valid ? r_ddram[w_mon_idx] : 8'h20;

            if (w_strobe && !r_rw_q) begin
                if (w_busy) begin
                    timing_err <= 1'b1;
                end else if (!four_bit) begin
                    r_exec      <= 1'b1;
                    r_exec_rs   <= r_rs_q;
                    r_exec_byte <= {r_data_q, 4'h0};
                end else if (!r_phase_low) begin
                    r_hi_nib    <= r_data_q;
                    r_phase_low <= 1'b1;
                end else begin
                    r_exec      <= 1'b1;
                    r_exec_rs   <= r_rs_q;
                    r_exec_byte <= {r_hi_nib, r_data_q};
                    r_phase_low <= 1'b0;
                end
            end

            // Instruction decode, highest set bit wins.
            if (r_exec) begin
                if (r_exec_rs) begin
                    if (!r_cgram_sel) ac <= ac_step(ac, r_id, two_line);
                end else if (r_exec_byte[7]) begin
                    ac          <= set_addr(r_exec_byte[6:0], two_line);
                    r_cgram_sel <= 1'b0;
                end else if (r_exec_byte[6]) begin
                    r_cgram_sel <= 1'b1;
                end else if (r_exec_byte[5]) begin
                    two_line <= r_exec_byte[3];
                    if (!four_bit && !r_exec_byte[4]) begin
                        four_bit    <= 1'b1;
                        r_phase_low <= 1'b0;
                    end
                end else if (r_exec_byte[4]) begin
                    if (!r_exec_byte[3]) ac <= ac_step(ac, r_exec_byte[2], two_line);
                end else if (r_exec_byte[3]) begin
                    {disp_on, cursor_on, blink_on} <= r_exec_byte[2:0];
                end else if (r_exec_byte[2]) begin
                    r_id <= r_exec_byte[1];
                end else if (r_exec_byte[1]) begin
                    ac <= 7'h00;
                end else if (r_exec_byte[0]) begin
                    ac   <= 7'h00;
                    r_id <= 1'b1;
                end
            end
        end
    end

    // Display memory is deliberately not reset; an aborted clear keeps what it had reached.
    always_ff @(posedge clk) begin
        if (w_fill)
            r_ddram[r_clr_idx] <= 8'h20;
        else if (r_exec && r_exec_rs && !r_cgram_sel && w_ac_valid)
            r_ddram[w_ac_idx] <= r_exec_byte;
    end

endmodule
